fetch_seq: RTL and testbench
============================

# fetch_seq

Fetch sequencer that drives the stall and next-PC inputs of the PC register and owns the single-outstanding instruction-memory handshake. It sits between the PC register, instruction memory and the IF/ID boundary. It merges exception, `eret` and branch redirects by priority and holds any redirect that arrives while a fetch is in flight. It delivers one instruction at a time downstream under a valid/stall handshake.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch address after reset
- `EXC_VECTOR`, 32'h0000_4180, exception/interrupt entry
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low (asserted at 0)
- `pc` in 32: current PC register value
- `pc_stall` out 1: 0 = PC register loads `npc` this edge
- `npc` out 32: next PC value
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address
- `imem_gnt` in 1: request accepted
- `imem_rvalid` in 1: read data valid
- `imem_rdata` in 32: read data
- `if_valid` out 1: instruction valid to IF/ID
- `if_instr` out 32: instruction word
- `if_pc` out 32: address of `if_instr`
- `id_stall` in 1: downstream cannot accept
- `br_redirect` in 1, `br_target` in 32: branch/jump redirect, one-cycle pulse
- `eret` in 1, `epc` in 32: return-from-exception pulse and target
- `exc_req` in 1: exception/interrupt pulse, target `EXC_VECTOR`

## Operation
- States: IDLE, FETCH, WAIT, VALID.
- IDLE → FETCH next cycle. `imem_req`=0 in IDLE.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. Both are held stable until `imem_gnt`. On `imem_gnt`, go to WAIT.
- WAIT: on `imem_rvalid`:
  - No redirect pending or arriving: capture `imem_rdata`→`if_instr` and `pc`→`if_pc`, go to VALID.
  - Redirect pending or arriving this cycle: discard data, apply redirect, go to FETCH.
- VALID: `if_valid`=1. When `id_stall`=0, the instruction is consumed: `pc_stall`=0, `npc`=`pc`+4 (mod 2^32), go to FETCH. When `id_stall`=1, stay in VALID with outputs frozen.
- Redirect priority within one cycle: `exc_req` > `eret` > `br_redirect`.
  - Target is `EXC_VECTOR`, `epc` or `br_target`.
  - A new event replaces a pending one unless the pending one has strictly higher priority.
- Redirect application:
  - Immediate in IDLE and VALID.
  - In FETCH and WAIT, the event is held pending until `imem_rvalid`.
  - Applying a redirect sets `pc_stall`=0 and `npc`=target, clears pending, and goes to FETCH.
- VALID with `id_stall`=0 and a redirect in the same cycle: the instruction is consumed (delay slot delivered) and `npc`=redirect target, not `pc`+4.
- VALID with `id_stall`=1 and a redirect: the held instruction is dropped (`if_valid`=0 next cycle) and the redirect is applied.
- Default `pc_stall`=1 and `npc`=`pc`+4 whenever no load is specified.
- `imem_rvalid` outside WAIT and `imem_gnt` outside FETCH are ignored.

## Timing
- Reset values (asynchronous):
  - state=IDLE, pending cleared
  - `pc_stall`=1, `imem_req`=0, `if_valid`=0
  - `if_instr`=0, `if_pc`=`RESET_PC`
- Minimum fetch is 3 cycles per instruction with zero-wait memory: FETCH+gnt, WAIT+rvalid, VALID.
- `if_valid` rises the cycle after `imem_rvalid`.
- `pc_stall`/`npc` are combinational from state, pending, redirect inputs and `id_stall`. The PC register updates at the edge ending that cycle.
- Reset mid-WAIT: the outstanding response is abandoned. A late `imem_rvalid` after release is ignored because the block is in IDLE or FETCH.
- All registered outputs change only on the rising `clk` edge, except during asynchronous reset.

## Structure
- Package `fetch_pkg`:
  - state enum (IDLE, FETCH, WAIT, VALID)
  - redirect priority enum (NONE, BR, ERET, EXC)
  - `RESET_PC`/`EXC_VECTOR` defaults
- Sub-module `redirect_buf`: pending valid/priority/target register with priority merge; outputs `pend_valid`, `pend_target`, `merged_target`.
- Top level: FSM, output registers, `npc` mux.

## Test plan
- Reset release, memory answering gnt+rvalid immediately:
  - `imem_addr`=0x3000; `if_valid` with `if_pc`=0x3000; then `imem_addr`=0x3004.
  - Steady state is one instruction every 3 cycles.
- `id_stall`=1 for 4 cycles in VALID: `if_instr`/`if_pc` frozen, `pc_stall`=1 throughout; PC advances only after release.
- `br_redirect` (target 0x3100) in WAIT, rvalid 2 cycles later: data discarded, no `if_valid`, `npc`=0x3100, next `imem_addr`=0x3100.
- `br_redirect` 0x3100 then `exc_req` while in WAIT: `npc`=0x4180. `exc_req` then `br_redirect`: still 0x4180.
- Same cycle `exc_req`, `eret` (`epc`=0x3200), `br_redirect` in VALID with `id_stall`=0: instruction consumed, `npc`=0x4180.
- Assert `reset` low during WAIT, then rvalid after release: ignored; first fetch restarts at 0x3000 and all reset values hold.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and defaults for the fetch sequencer.
//   - fetch_state_e : sequencer states (IDLE, FETCH, WAIT, VALID)
//   - redir_prio_e  : redirect source ordered by priority (NONE < BR < ERET < EXC)
//   - RESET_PC_DEF / EXC_VECTOR_DEF : default fetch-after-reset and exception entry
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } fetch_state_e;

   // Encoding order is the priority order; comparisons rely on it.
   typedef enum logic [1:0] {
      PRIO_NONE = 2'd0,
      PRIO_BR   = 2'd1,
      PRIO_ERET = 2'd2,
      PRIO_EXC  = 2'd3
   } redir_prio_e;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage : fetch_pkg

// File: rtl/fetch_seq_redirect_buf.sv
// redirect_buf
//   Holds at most one pending redirect (priority + target) and merges it
//   with the redirect arriving this cycle.
//   Ports:
//     clk, reset          : clock, asynchronous active-low reset
//     exc_req             : exception pulse (target EXC_VECTOR)
//     eret, epc           : return-from-exception pulse and target
//     br_redirect, br_target : branch/jump pulse and target
//     hold_i              : record the merged redirect as pending this edge
//     clear_i             : redirect applied this cycle, drop pending
//     arr_valid_o         : some redirect arrives this cycle
//     pend_valid          : a redirect is pending
//     pend_target         : target of the pending redirect
//     merged_target       : winner of arriving vs pending (arriving wins ties)
module redirect_buf
   import fetch_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        br_redirect,
   input  logic [31:0] br_target,
   input  logic        hold_i,
   input  logic        clear_i,
   output logic        arr_valid_o,
   output logic        pend_valid,
   output logic [31:0] pend_target,
   output logic [31:0] merged_target
);

   redir_prio_e pend_prio_q, pend_prio_d;
   logic [31:0] pend_target_q, pend_target_d;
   redir_prio_e arr_prio;
   logic [31:0] arr_target;
   redir_prio_e merged_prio;
   logic        take_new;

   // Same-cycle priority among arriving events.
   always_comb begin
      arr_prio   = PRIO_NONE;
      arr_target = '0;
      if (exc_req) begin
         arr_prio   = PRIO_EXC;
         arr_target = EXC_VECTOR;
      end else if (eret) begin
         arr_prio   = PRIO_ERET;
         arr_target = epc;
      end else if (br_redirect) begin
         arr_prio   = PRIO_BR;
         arr_target = br_target;
      end
   end

   // A new event replaces the pending one unless pending is strictly higher.
   assign take_new      = (arr_prio != PRIO_NONE) && (arr_prio >= pend_prio_q);
   assign merged_prio   = take_new ? arr_prio : pend_prio_q;
   assign merged_target = take_new ? arr_target : pend_target_q;

   always_comb begin
      pend_prio_d   = pend_prio_q;
      pend_target_d = pend_target_q;
      if (clear_i) begin
         pend_prio_d   = PRIO_NONE;
         pend_target_d = '0;
      end else if (hold_i && take_new) begin
         pend_prio_d   = merged_prio;
         pend_target_d = merged_target;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_prio_q   <= PRIO_NONE;
         pend_target_q <= '0;
      end else begin
         pend_prio_q   <= pend_prio_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign arr_valid_o = (arr_prio != PRIO_NONE);
   assign pend_valid  = (pend_prio_q != PRIO_NONE);
   assign pend_target = pend_target_q;

endmodule : redirect_buf

// File: rtl/fetch_seq.sv
// fetch_seq
//   Fetch sequencer: drives PC-register stall/next-PC, owns a single
//   outstanding instruction-memory request and hands one instruction at a
//   time to IF/ID. Exception/eret/branch redirects are merged by priority and
//   held while a fetch is in flight.
//   Ports:
//     clk, reset                 : clock, asynchronous active-low reset
//     pc                         : current PC register value
//     pc_stall, npc              : 0 => PC register loads npc this edge
//     imem_req, imem_addr        : fetch request and address (held until gnt)
//     imem_gnt                   : request accepted
//     imem_rvalid, imem_rdata    : read response
//     if_valid, if_instr, if_pc  : instruction to IF/ID
//     id_stall                   : downstream cannot accept
//     br_redirect, br_target     : branch/jump redirect pulse
//     eret, epc                  : return-from-exception pulse and target
//     exc_req                    : exception/interrupt pulse
module fetch_seq
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pc_stall,
   output logic [31:0] npc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_stall,
   input  logic        br_redirect,
   input  logic [31:0] br_target,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        exc_req
);

   fetch_state_e state_q, state_d;
   logic [31:0]  if_instr_q, if_pc_q;
   logic         cap_en;
   logic         buf_hold, buf_clear;
   logic         arr_valid, pend_valid;
   logic [31:0]  pend_target, merged_target;
   logic         redir_any;
   logic [31:0]  redir_target;
   logic [31:0]  pc_plus4;

   redirect_buf #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_redirect_buf (
      .clk           (clk),
      .reset         (reset),
      .exc_req       (exc_req),
      .eret          (eret),
      .epc           (epc),
      .br_redirect   (br_redirect),
      .br_target     (br_target),
      .hold_i        (buf_hold),
      .clear_i       (buf_clear),
      .arr_valid_o   (arr_valid),
      .pend_valid    (pend_valid),
      .pend_target   (pend_target),
      .merged_target (merged_target)
   );

   assign redir_any    = arr_valid | pend_valid;
   assign redir_target = arr_valid ? merged_target : pend_target;
   assign pc_plus4     = pc + 32'd4;

   always_comb begin
      state_d   = state_q;
      pc_stall  = 1'b1;
      npc       = pc_plus4;
      imem_req  = 1'b0;
      cap_en    = 1'b0;
      buf_hold  = 1'b0;
      buf_clear = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            if (redir_any) begin
               pc_stall  = 1'b0;
               npc       = redir_target;
               buf_clear = 1'b1;
            end
         end
         S_FETCH: begin
            // pc must not move while the request is outstanding; defer redirects.
            imem_req = 1'b1;
            buf_hold = 1'b1;
            if (imem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            buf_hold = 1'b1;
            if (imem_rvalid) begin
               if (redir_any) begin
                  pc_stall  = 1'b0;
                  npc       = redir_target;
                  buf_clear = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  cap_en  = 1'b1;
                  state_d = S_VALID;
               end
            end
         end
         S_VALID: begin
            // With id_stall=0 the instruction is consumed either way; with
            // id_stall=1 a redirect drops it.
            if (redir_any) begin
               pc_stall  = 1'b0;
               npc       = redir_target;
               buf_clear = 1'b1;
               state_d   = S_FETCH;
            end else if (!id_stall) begin
               pc_stall = 1'b0;
               state_d  = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         if_instr_q <= '0;
         if_pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         if (cap_en) begin
            if_instr_q <= imem_rdata;
            if_pc_q    <= pc;
         end
      end
   end

   assign imem_addr = pc;
   assign if_valid  = (state_q == S_VALID);
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;

endmodule : fetch_seq

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        pc_stall;
   logic [31:0] npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_stall;
   logic        br_redirect;
   logic [31:0] br_target;
   logic        eret;
   logic [31:0] epc;
   logic        exc_req;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic        gnt_en;
   int          rv_delay;
   logic [31:0] addr_q[$];
   logic [31:0] dpc_q[$];
   logic [31:0] dinstr_q[$];

   fetch_seq #(
      .RESET_PC   (32'h0000_3000),
      .EXC_VECTOR (32'h0000_4180)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .pc_stall    (pc_stall),
      .npc         (npc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .id_stall    (id_stall),
      .br_redirect (br_redirect),
      .br_target   (br_target),
      .eret        (eret),
      .epc         (epc),
      .exc_req     (exc_req)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // PC register in front of the sequencer
   always @(posedge clk or negedge reset) begin
      if (!reset) pc <= 32'h0000_3000;
      else if (!pc_stall) pc <= npc;
   end

   assign imem_gnt = imem_req & gnt_en;

   // Memory: answers rv_delay cycles after the grant, data = addr ^ A5A50000.
   initial begin : mem_model
      logic        granted, pend_rv;
      logic [31:0] addr_l, raddr;
      int          cnt;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pend_rv     = 1'b0;
      raddr       = '0;
      cnt         = 0;
      forever begin
         @(negedge clk);
         granted = imem_req && imem_gnt && reset;
         addr_l  = imem_addr;
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (granted) begin
            pend_rv = 1'b1;
            cnt     = rv_delay;
            raddr   = addr_l;
         end
         if (pend_rv) begin
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = raddr ^ 32'hA5A5_0000;
               pend_rv     = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (reset && imem_req && imem_gnt) begin
         if (addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL fetch_addr: unexpected fetch of 0x%08h, none expected", imem_addr);
         end else begin
            check("fetch_addr", imem_addr, addr_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (reset && if_valid && !id_stall) begin
         if (dpc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL deliver: unexpected instr pc=0x%08h, none expected", if_pc);
         end else begin
            check("deliver_pc", if_pc, dpc_q.pop_front());
            check("deliver_instr", if_instr, dinstr_q.pop_front());
         end
      end
   end

   // 0: if_valid, 1: consume, 2: fetch handshake, 3: imem_rvalid
   task automatic wait_for(input int what, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         case (what)
            0: hit = if_valid;
            1: hit = if_valid && !id_stall;
            2: hit = imem_req && imem_gnt;
            default: hit = imem_rvalid;
         endcase
      end
      tests++;
      if (!hit) begin
         fails++;
         $display("FAIL %s: timeout got no event expected event within 40 cycles", name);
      end
   endtask

   task automatic push_deliver(input logic [31:0] p, input logic [31:0] ins);
      dpc_q.push_back(p);
      dinstr_q.push_back(ins);
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   initial begin : stim
      int t1, t2, t3;
      reset       = 1'b0;
      id_stall    = 1'b0;
      br_redirect = 1'b0;
      br_target   = '0;
      eret        = 1'b0;
      epc         = '0;
      exc_req     = 1'b0;
      gnt_en      = 1'b1;
      rv_delay    = 0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_pc_stall", {31'd0, pc_stall}, 32'd1);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_if_pc", if_pc, 32'h0000_3000);

      // Back-to-back fetches, zero-wait memory
      addr_q.push_back(32'h3000); addr_q.push_back(32'h3004);
      addr_q.push_back(32'h3008); addr_q.push_back(32'h300C);
      push_deliver(32'h3000, 32'hA5A5_3000);
      push_deliver(32'h3004, 32'hA5A5_3004);
      push_deliver(32'h3008, 32'hA5A5_3008);
      push_deliver(32'h300C, 32'hA5A5_300C);
      step; reset = 1'b1;
      wait_for(1, "consume_3000"); t1 = cyc;
      wait_for(1, "consume_3004"); t2 = cyc;
      wait_for(1, "consume_3008"); t3 = cyc;
      check("period_1", t2 - t1, 32'd3);
      check("period_2", t3 - t2, 32'd3);

      // Downstream stall for 4 cycles in VALID
      step; id_stall = 1'b1;
      wait_for(0, "valid_300C");
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("stall_if_pc", if_pc, 32'h300C);
         check("stall_if_instr", if_instr, 32'hA5A5_300C);
         check("stall_pc_stall", {31'd0, pc_stall}, 32'd1);
         check("stall_pc_hold", pc, 32'h300C);
      end
      addr_q.push_back(32'h3010);
      addr_q.push_back(32'h3100);
      push_deliver(32'h3100, 32'hA5A5_3100);
      step; id_stall = 1'b0; rv_delay = 2;

      // Branch in WAIT, rvalid two cycles later: data discarded
      wait_for(2, "fetch_3010");
      step; br_redirect = 1'b1; br_target = 32'h3100;
      step; br_redirect = 1'b0;
      @(negedge clk);
      check("br_pending_stall", {31'd0, pc_stall}, 32'd1);
      wait_for(3, "rvalid_3010");
      check("br_wait_pc_stall", {31'd0, pc_stall}, 32'd0);
      check("br_wait_npc", npc, 32'h3100);
      rv_delay = 0;
      wait_for(1, "consume_3100");

      // br then exc, and exc then br, both while in WAIT
      rv_delay = 2;
      addr_q.push_back(32'h3104);
      addr_q.push_back(32'h4180);
      addr_q.push_back(32'h4180);
      push_deliver(32'h4180, 32'hA5A5_4180);
      wait_for(2, "fetch_3104");
      step; br_redirect = 1'b1; br_target = 32'h3100;
      step; br_redirect = 1'b0; exc_req = 1'b1;
      step; exc_req = 1'b0;
      wait_for(3, "rvalid_3104");
      check("br_exc_npc", npc, 32'h4180);
      wait_for(2, "fetch_4180a");
      step; exc_req = 1'b1;
      step; exc_req = 1'b0; br_redirect = 1'b1; br_target = 32'h3300;
      step; br_redirect = 1'b0;
      wait_for(3, "rvalid_4180a");
      check("exc_br_npc", npc, 32'h4180);
      check("exc_br_pc_stall", {31'd0, pc_stall}, 32'd0);
      rv_delay = 0;
      id_stall = 1'b1;

      // All three redirects in VALID with id_stall=0: delay slot consumed
      wait_for(0, "valid_4180");
      addr_q.push_back(32'h4180);
      addr_q.push_back(32'h3200);
      push_deliver(32'h3200, 32'hA5A5_3200);
      step;
      exc_req = 1'b1; eret = 1'b1; epc = 32'h3200;
      br_redirect = 1'b1; br_target = 32'h3300; id_stall = 1'b0;
      @(negedge clk);
      check("triple_pc_stall", {31'd0, pc_stall}, 32'd0);
      check("triple_npc", npc, 32'h4180);
      step;
      exc_req = 1'b0; eret = 1'b0; br_redirect = 1'b0; id_stall = 1'b1;

      // eret beats branch in VALID with id_stall=1: held instruction dropped
      wait_for(0, "valid_4180_held");
      step; eret = 1'b1; epc = 32'h3200; br_redirect = 1'b1; br_target = 32'h3300;
      @(negedge clk);
      check("eret_npc", npc, 32'h3200);
      check("eret_pc_stall", {31'd0, pc_stall}, 32'd0);
      step; eret = 1'b0; br_redirect = 1'b0; id_stall = 1'b0;
      @(negedge clk);
      check("drop_if_valid", {31'd0, if_valid}, 32'd0);
      wait_for(1, "consume_3200");

      // Reset during WAIT, late rvalid after release is ignored
      rv_delay = 5;
      addr_q.push_back(32'h3204);
      wait_for(2, "fetch_3204");
      step; reset = 1'b0;
      @(negedge clk);
      check("rst2_pc_stall", {31'd0, pc_stall}, 32'd1);
      check("rst2_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst2_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst2_if_instr", if_instr, 32'h0);
      check("rst2_if_pc", if_pc, 32'h3000);
      gnt_en = 1'b0;
      @(posedge clk);
      step; reset = 1'b1;
      wait_for(3, "late_rvalid");
      check("late_imem_req", {31'd0, imem_req}, 32'd1);
      check("late_if_valid", {31'd0, if_valid}, 32'd0);
      check("late_imem_addr", imem_addr, 32'h3000);
      addr_q.push_back(32'h3000);
      push_deliver(32'h3000, 32'hA5A5_3000);
      rv_delay = 0;
      step; gnt_en = 1'b1;
      wait_for(1, "consume_3000_again");

      step;
      check("addr_q_drained", addr_q.size(), 32'd0);
      check("deliver_q_drained", dpc_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_fetch_seq
